// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: request/grant bundle between the transmit sources, the PHY
// send stage and the tx path arbiter.
//   req        4  transmit requests (bit0 ARP, bit1 ICMP, bit2 DHCP, bit3 UDP)
//   tx_active  1  PHY send stage is emitting a frame
//   grant      4  one-hot owner of the tx path, zero when unowned
//   protocol   2  encoded owner (0 ARP, 1 ICMP, 2 DHCP, 3 UDP)
//   tx_start   1  enable to the granted source, held until tx_active seen
//   busy       1  arbiter not idle
//   timeout    1  one-clock pulse when a granted source never started
// master: the arbiter side.  slave: sources / PHY side.
interface tx_arbiter_if;
  logic [3:0] req;
  logic       tx_active;
  logic [3:0] grant;
  logic [1:0] protocol;
  logic       tx_start;
  logic       busy;
  logic       timeout;

  modport master (
    input  req, tx_active,
    output grant, protocol, tx_start, busy, timeout
  );

  modport slave (
    output req, tx_active,
    input  grant, protocol, tx_start, busy, timeout
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: grants the shared tx path to one of four protocol sources.
// Fixed priority ARP > ICMP > DHCP > UDP, with a starvation override that
// hands the path to UDP after STARVE_LIMIT consecutive non-UDP grants taken
// while UDP was waiting. Each grant runs IDLE -> START -> BUSY -> GAP, where
// GAP enforces the inter-frame gap. All outputs are registered.
// Ports:
//   clock  tx clock, rising edge
//   reset  synchronous, active-high
//   bus    tx_arbiter_if.master (req, tx_active in; grant, protocol,
//          tx_start, busy, timeout out)
module tx_arbiter #(
  parameter int unsigned IFG_CYCLES    = 24,
  parameter int unsigned START_TIMEOUT = 255,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic          clock,
  input  logic          reset,
  tx_arbiter_if.master  bus
);

  localparam logic [8:0] TO_LIM = 9'(START_TIMEOUT);
  localparam logic [7:0] SV_LIM = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t      state_q, state_n;
  logic [3:0]  grant_q, grant_n;
  logic [1:0]  proto_q, proto_n;
  logic        start_q, start_n;
  logic        busy_q;
  logic        tmo_q, tmo_n;
  logic [8:0]  timer_q, timer_n;
  logic [15:0] gap_q, gap_n;
  logic [7:0]  starve_q, starve_n;
  logic [1:0]  win;

  // Winner: UDP forced once it has been passed over STARVE_LIMIT times.
  always_comb begin
    win = 2'd3;
    if (bus.req[3] && starve_q == SV_LIM) win = 2'd3;
    else if (bus.req[0])                  win = 2'd0;
    else if (bus.req[1])                  win = 2'd1;
    else if (bus.req[2])                  win = 2'd2;
  end

  always_comb begin
    state_n  = state_q;
    grant_n  = grant_q;
    proto_n  = proto_q;
    start_n  = start_q;
    tmo_n    = 1'b0;
    timer_n  = timer_q;
    gap_n    = gap_q;
    starve_n = starve_q;
    case (state_q)
      IDLE: begin
        if (!bus.req[3]) starve_n = '0;
        // A frame still on the wire (spurious tx_active) blocks arbitration.
        if (!bus.tx_active && bus.req != 4'd0) begin
          state_n = START;
          grant_n = 4'(4'b0001 << win);
          proto_n = win;
          start_n = 1'b1;
          timer_n = '0;
          if (win == 2'd3)                          starve_n = '0;
          else if (bus.req[3] && starve_q < SV_LIM) starve_n = starve_q + 8'd1;
        end
      end
      START: begin
        // tx_active takes precedence over a timeout landing on the same edge.
        if (bus.tx_active) begin
          state_n = BUSY;
          start_n = 1'b0;
        end else if (timer_q + 9'd1 == TO_LIM) begin
          state_n = GAP;
          grant_n = '0;
          start_n = 1'b0;
          tmo_n   = 1'b1;
          gap_n   = '0;
        end else begin
          timer_n = timer_q + 9'd1;
        end
      end
      BUSY: begin
        if (!bus.tx_active) begin
          state_n = GAP;
          grant_n = '0;
          gap_n   = '0;
        end
      end
      GAP: begin
        // IFG_CYCLES clocks in GAP; IFG_CYCLES=0 still spends one clock here.
        if (32'(gap_q) + 32'd1 >= IFG_CYCLES) state_n = IDLE;
        else                                  gap_n   = gap_q + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      proto_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      timer_q  <= '0;
      gap_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_n;
      grant_q  <= grant_n;
      proto_q  <= proto_n;
      start_q  <= start_n;
      busy_q   <= (state_n != IDLE);
      tmo_q    <= tmo_n;
      timer_q  <= timer_n;
      gap_q    <= gap_n;
      starve_q <= starve_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.protocol = proto_q;
  assign bus.tx_start = start_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = tmo_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with default parameters (IFG 24, start
// timeout 255, starve limit 4). Inputs change 1 ns after the rising edge,
// outputs are sampled there too.
module tb_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tx_arbiter_if ifc ();
  tx_arbiter dut (.clock(clock), .reset(reset), .bus(ifc));

  int  vectors     = 0;
  int  miscompares = 0;
  bit  armed       = 1'b0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0;
    while (ifc.grant == 4'd0 && n < max) begin
      tick;
      n++;
    end
  endtask

  // Continuous invariants: grant one-hot or zero, busy mirrors state != IDLE.
  always @(negedge clock) begin
    if (armed) begin
      vectors++;
      assert ($onehot0(ifc.grant)) else begin
        miscompares++;
        $error("FAIL onehot: observed grant %b expected one-hot or zero", ifc.grant);
      end
      vectors++;
      assert (ifc.busy === (dut.state_q != 2'd0)) else begin
        miscompares++;
        $error("FAIL busy_state: observed busy %b expected %b", ifc.busy, dut.state_q != 2'd0);
      end
    end
  end

  initial begin
    int n;
    logic [3:0] arb_exp [6];
    arb_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001};

    ifc.req       = 4'd0;
    ifc.tx_active = 1'b0;
    reset         = 1'b1;
    tick;
    armed = 1'b1;
    tick;
    chk("rst_grant",    ifc.grant,    0);
    chk("rst_protocol", ifc.protocol, 0);
    chk("rst_tx_start", ifc.tx_start, 0);
    chk("rst_busy",     ifc.busy,     0);
    chk("rst_timeout",  ifc.timeout,  0);
    chk("rst_starve",   dut.starve_q, 0);

    // Arbitration order with all four requesting; 10-clock frames.
    reset   = 1'b0;
    ifc.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_grant(40, n);
      chk("arb_latency", n, (i == 0) ? 1 : 25);
      chk("arb_grant", ifc.grant, arb_exp[i]);
      if (i == 5) ifc.req = 4'd0;
      ifc.tx_active = 1'b1;
      repeat (10) tick;
      ifc.tx_active = 1'b0;
      tick;
      chk("arb_release", ifc.grant, 0);
    end
    repeat (24) tick;
    chk("gap_to_idle", ifc.busy, 0);

    // One-clock DHCP request; tx_active 3 clocks after tx_start, 20 long.
    ifc.req = 4'b0100;
    tick;
    chk("dhcp_grant",    ifc.grant,    4'b0100);
    chk("dhcp_protocol", ifc.protocol, 2);
    chk("dhcp_tx_start", ifc.tx_start, 1);
    ifc.req = 4'd0;
    repeat (3) tick;
    chk("dhcp_start_hold", ifc.tx_start, 1);
    chk("dhcp_grant_hold", ifc.grant,    4'b0100);
    ifc.tx_active = 1'b1;
    tick;
    chk("dhcp_start_fall", ifc.tx_start, 0);
    chk("dhcp_busy",       ifc.busy,     1);
    repeat (19) tick;
    ifc.tx_active = 1'b0;
    tick;
    chk("dhcp_gap_grant",  ifc.grant,    0);
    chk("dhcp_proto_keep", ifc.protocol, 2);
    ifc.req = 4'b0010;
    wait_grant(60, n);
    chk("gap_length",    n,            25);
    chk("icmp_grant",    ifc.grant,    4'b0010);
    chk("icmp_protocol", ifc.protocol, 1);

    // Start timeout: tx_active never rises.
    ifc.req = 4'd0;
    n = 0;
    while (!ifc.timeout && n < 400) begin
      tick;
      n++;
    end
    chk("timeout_delay",    n,            255);
    chk("timeout_grant",    ifc.grant,    0);
    chk("timeout_tx_start", ifc.tx_start, 0);
    chk("timeout_busy",     ifc.busy,     1);
    chk("timeout_protocol", ifc.protocol, 1);

    // GAP ignores req; then spurious tx_active in IDLE blocks the grant.
    ifc.tx_active = 1'b1;
    ifc.req       = 4'b1000;
    tick;
    chk("timeout_pulse_end", ifc.timeout, 0);
    repeat (22) tick;
    chk("gap_ignore_req", ifc.grant, 0);
    chk("gap_last_busy",  ifc.busy,  1);
    tick;
    chk("gap_done_idle",  ifc.busy,  0);
    repeat (5) tick;
    chk("spurious_no_grant", ifc.grant, 0);
    ifc.tx_active = 1'b0;
    tick;
    chk("udp_grant",    ifc.grant,    4'b1000);
    chk("udp_protocol", ifc.protocol, 3);

    // tx_active arriving on the timeout edge wins.
    repeat (254) tick;
    ifc.tx_active = 1'b1;
    tick;
    chk("race_no_timeout", ifc.timeout,  0);
    chk("race_grant",      ifc.grant,    4'b1000);
    chk("race_tx_start",   ifc.tx_start, 0);
    ifc.tx_active = 1'b0;
    tick;
    ifc.req = 4'b1001;
    wait_grant(40, n);
    chk("arp_over_udp", ifc.grant,    4'b0001);
    chk("starve_one",   dut.starve_q, 1);

    // Reset in the middle of a frame.
    ifc.tx_active = 1'b1;
    tick;
    tick;
    chk("mid_busy", ifc.busy, 1);
    reset = 1'b1;
    tick;
    chk("mid_rst_grant",    ifc.grant,    0);
    chk("mid_rst_protocol", ifc.protocol, 0);
    chk("mid_rst_tx_start", ifc.tx_start, 0);
    chk("mid_rst_busy",     ifc.busy,     0);
    chk("mid_rst_timeout",  ifc.timeout,  0);
    chk("mid_rst_starve",   dut.starve_q, 0);
    reset         = 1'b0;
    ifc.tx_active = 1'b0;
    tick;
    chk("post_rst_grant",    ifc.grant,    4'b0001);
    chk("post_rst_tx_start", ifc.tx_start, 1);
    chk("post_rst_timeout",  ifc.timeout,  0);
    ifc.req = 4'd0;
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
